// File: rtl/laser_pkg.sv
// Shared definitions for the laser receive array: lane FSM states and line polarity.
package laser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } lane_state_t;

    localparam logic IDLE_LVL  = 1'b0;
    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;

endpackage

// File: rtl/laser_rx_lane.sv
// One laser receive lane: input synchronizer, start/data/stop FSM, 3-sample majority voter
// and LSB-first shift register. Emits a one-cycle commit strobe with the received word.
module laser_rx_lane
    import laser_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              line_in,
    output logic              commit,
    output logic [DATA_W-1:0] commit_data,
    output logic              frame_err
);

    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_W);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_EARLY = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_MID   = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0] PH_LATE  = PH_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(DATA_W - 1);

    logic [1:0]        sync_q;
    logic              line_s;
    logic              line_prev;
    lane_state_t       state;
    logic [PH_W-1:0]   phase;
    logic [1:0]        votes;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] shift_q;

    logic       in_window;
    logic [1:0] vote_sum;
    logic       bit_val;
    logic       at_last;

    assign line_s = sync_q[1];

    // For OVERSAMPLE=4 the late sample lands on the decision phase, so the
    // current sample is folded into the vote combinationally.
    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        in_window = (phase == PH_EARLY) || (phase == PH_MID) || (phase == PH_LATE);
        vote_sum  = votes + {1'b0, in_window & line_s};
        bit_val   = vote_sum[1];
        at_last   = (state != IDLE) && (phase == PH_LAST);
        commit    = at_last && (state == STOP) && (bit_val == STOP_LVL);
    end

    assign commit_data = shift_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            line_prev <= IDLE_LVL;
            state     <= IDLE;
            phase     <= '0;
            votes     <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            frame_err <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], line_in};
            line_prev <= line_s;
            frame_err <= 1'b0;

            if (state == IDLE) begin
                if (line_s == START_LVL && line_prev == IDLE_LVL) begin
                    state <= START;
                    phase <= '0;
                    votes <= '0;
                end
            end else begin
                phase <= at_last ? '0 : phase + 1'b1;
                votes <= at_last ? '0 : vote_sum;
                if (at_last) begin
                    case (state)
                        START: begin
                            if (bit_val == START_LVL) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state     <= IDLE;
                                frame_err <= 1'b1;
                            end
                        end
                        DATA: begin
                            shift_q <= {bit_val, shift_q[DATA_W-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BC_LAST) state <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            if (bit_val != STOP_LVL) frame_err <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/laser_rx_array.sv
// Array of independent laser receive lanes; per-lane word buffers realign skewed lanes
// and present one concatenated word with a valid/ready handshake.
module laser_rx_array
    import laser_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        laser_in,
    output logic [CHANNELS*DATA_W-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS-1:0]        frame_err,
    output logic [CHANNELS-1:0]        overrun,
    input  logic                       overrun_clr
);

    logic [CHANNELS-1:0] lane_full;
    logic                handshake;

    assign out_valid = &lane_full;
    assign handshake = out_valid & out_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic              commit;
        logic [DATA_W-1:0] commit_data;
        logic [DATA_W-1:0] buffer_q;
        logic              full_q;
        logic              overrun_q;

        laser_rx_lane #(
            .DATA_W    (DATA_W),
            .OVERSAMPLE(OVERSAMPLE)
        ) u_lane (
            .clock      (clock),
            .reset      (reset),
            .line_in    (laser_in[i]),
            .commit     (commit),
            .commit_data(commit_data),
            .frame_err  (frame_err[i])
        );

        // A commit coinciding with the handshake refills the emptied slot, so it is not an overrun.
        // NOTE: the word buffers are reset because out_data must read zero after reset.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                buffer_q  <= '0;
                full_q    <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                if (commit && full_q && !handshake) overrun_q <= 1'b1;
                else if (overrun_clr)               overrun_q <= 1'b0;

                if (commit && (!full_q || handshake)) begin
                    buffer_q <= commit_data;
                    full_q   <= 1'b1;
                end else if (handshake) begin
                    full_q <= 1'b0;
                end
            end
        end

        assign lane_full[i]                  = full_q;
        assign overrun[i]                    = overrun_q;
        assign out_data[i*DATA_W +: DATA_W]  = buffer_q;
    end

endmodule

// File: tb/tb_laser_rx_array.sv
// Directed bench for laser_rx_array (2 lanes, 8-bit words, 8x oversampling).
module tb_laser_rx_array;

    localparam int CH    = 2;
    localparam int DW    = 8;
    localparam int OS    = 8;
    localparam int FRAME = (DW + 2) * OS;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [CH-1:0]     laser_in = '0;
    logic [CH*DW-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CH-1:0]     frame_err;
    logic [CH-1:0]     overrun;
    logic              overrun_clr = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    int          valid_cnt;
    int          hs_cnt;
    int          first_valid;
    int          unstable;
    int          fe_cnt [CH];
    logic [15:0] hs_data;

    laser_rx_array #(
        .CHANNELS  (CH),
        .DATA_W    (DW),
        .OVERSAMPLE(OS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .laser_in   (laser_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] mk_frame(input logic [7:0] d, input logic stop);
        return {stop, d, 1'b1};
    endfunction

    function automatic logic line_lvl(input logic [9:0] f, input int off, input int c, input int glitch_t);
        int   t;
        logic b;
        if (off < 0) return 1'b0;
        t = c - off;
        if (t < 0 || t >= FRAME) return 1'b0;
        b = f[t / OS];
        if (t == glitch_t) b = ~b;
        return b;
    endfunction

    // Drives both lanes for a fixed number of cycles and records what the outputs did.
    task automatic run_frames(input logic [9:0] f0, input logic [9:0] f1, input int off0, input int off1,
                              input int glitch_t0, input int ready_at, input int cycles);
        logic        hold_prev = 1'b0;
        logic [15:0] prev_data = '0;
        valid_cnt   = 0;
        hs_cnt      = 0;
        first_valid = -1;
        unstable    = 0;
        fe_cnt[0]   = 0;
        fe_cnt[1]   = 0;
        hs_data     = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            if (out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = c;
            end
            if (hold_prev && out_data !== prev_data) unstable++;
            for (int i = 0; i < CH; i++) if (frame_err[i]) fe_cnt[i]++;
            laser_in = {line_lvl(f1, off1, c, -1), line_lvl(f0, off0, c, glitch_t0)};
            if (ready_at >= 0) out_ready = (c == ready_at);
            if (out_valid && out_ready) begin
                hs_cnt++;
                hs_data = out_data;
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_valid",   {31'd0, out_valid}, 32'd0);
        check("rst_data",    {16'd0, out_data},  32'd0);
        check("rst_ferr",    {30'd0, frame_err}, 32'd0);
        check("rst_overrun", {30'd0, overrun},   32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Aligned lanes, consumer always ready
        out_ready = 1'b1;
        run_frames(mk_frame(8'hA5, 1'b0), mk_frame(8'h3C, 1'b0), 0, 0, -1, -1, 100);
        check("aligned_hs_cnt",   hs_cnt,      1);
        check("aligned_vcnt",     valid_cnt,   1);
        check("aligned_data",     hs_data,     32'h3CA5);
        check("aligned_latency",  first_valid, 83);
        check("aligned_ferr",     fe_cnt[0] + fe_cnt[1], 0);

        // Lane1 lags lane0 by 37 cycles
        run_frames(mk_frame(8'h01, 1'b0), mk_frame(8'hFF, 1'b0), 0, 37, -1, -1, 140);
        check("skew_first_valid", first_valid, 120);
        check("skew_data",        hs_data,     32'hFF01);
        check("skew_hs_cnt",      hs_cnt,      1);

        // One-cycle glitch on the mid sample of data bit 3
        run_frames(mk_frame(8'h00, 1'b0), mk_frame(8'h00, 1'b0), 0, 0, 37, -1, 100);
        check("glitch_data",      hs_data,     32'h0000);
        check("glitch_hs_cnt",    hs_cnt,      1);
        check("glitch_ferr",      fe_cnt[0],   0);

        // Bad stop bit on lane0 only
        run_frames(mk_frame(8'h77, 1'b1), 10'd0, 0, -1, -1, -1, 100);
        check("badstop_ferr0",    fe_cnt[0],   1);
        check("badstop_ferr1",    fe_cnt[1],   0);
        check("badstop_valid",    valid_cnt,   0);
        run_frames(mk_frame(8'hC3, 1'b0), mk_frame(8'h18, 1'b0), 0, 0, -1, -1, 100);
        check("after_bad_data",   hs_data,     32'h18C3);
        check("after_bad_ovr",    {30'd0, overrun}, 32'd0);

        // Consumer stalled: second lane0 frame overruns
        out_ready = 1'b0;
        run_frames(mk_frame(8'h11, 1'b0), mk_frame(8'h99, 1'b0), 0, 0, -1, -1, 100);
        check("stall_valid",      {31'd0, out_valid}, 32'd1);
        run_frames(mk_frame(8'h22, 1'b0), 10'd0, 0, -1, -1, -1, 100);
        check("stall_overrun",    {30'd0, overrun}, 32'd1);
        check("stall_data",       {16'd0, out_data}, 32'h9911);
        check("stall_stable",     unstable,    0);
        check("stall_no_hs",      hs_cnt,      0);
        @(negedge clock);
        overrun_clr = 1'b1;
        @(negedge clock);
        overrun_clr = 1'b0;
        check("ovr_cleared",      {30'd0, overrun}, 32'd0);

        // Lane0 commit on the same edge as the handshake
        run_frames(mk_frame(8'h33, 1'b0), 10'd0, 0, -1, -1, 82, 100);
        check("coincide_hs_cnt",  hs_cnt,      1);
        check("coincide_hs_data", hs_data,     32'h9911);
        check("coincide_ovr",     {30'd0, overrun}, 32'd0);
        check("coincide_valid",   {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        run_frames(10'd0, mk_frame(8'h44, 1'b0), -1, 0, -1, -1, 100);
        check("refill_data",      hs_data,     32'h4433);
        check("refill_latency",   first_valid, 83);

        // Reset mid-frame at phase 3 of data bit 4
        run_frames(mk_frame(8'h5A, 1'b0), mk_frame(8'h5A, 1'b0), 0, 0, -1, -1, 46);
        @(negedge clock);
        reset    = 1'b1;
        laser_in = '0;
        @(negedge clock);
        check("midrst_valid",     {31'd0, out_valid}, 32'd0);
        check("midrst_data",      {16'd0, out_data},  32'd0);
        check("midrst_ferr",      {30'd0, frame_err}, 32'd0);
        check("midrst_ovr",       {30'd0, overrun},   32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        run_frames(mk_frame(8'h5A, 1'b0), mk_frame(8'h5A, 1'b0), 0, 0, -1, -1, 100);
        check("postrst_data",     hs_data,     32'h5A5A);
        check("postrst_hs_cnt",   hs_cnt,      1);
        check("postrst_ferr",     fe_cnt[0] + fe_cnt[1], 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/laser_rx_array.md
LASER_RX_ARRAY -- requirements
Module: laser_rx_array

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent laser receive lanes (1..8).
REQ-002 Parameter DATA_W, default 8, payload bits per frame (4..16).
REQ-003 Parameter OVERSAMPLE, default 8, clock cycles per bit period (4..255, even).
REQ-004 clock  input  1  sample clock, rising-edge; reset is asynchronous, active-high.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 laser_in  input  CHANNELS  raw photodiode lines, asynchronous to clock; bit i = lane i.
REQ-007 out_data  output  CHANNELS*DATA_W  aligned word; lane i in bits [i*DATA_W +: DATA_W].
REQ-008 out_valid  output  1  aligned word available.
REQ-009 out_ready  input  1  consumer accepts word.
REQ-010 frame_err  output  CHANNELS  one-cycle pulse per lane on bad stop bit or false start.
REQ-011 overrun  output  CHANNELS  sticky per-lane flag: a frame was dropped because the lane buffer was full.
REQ-012 overrun_clr  input  1  clears all overrun bits.

Function
REQ-013 Line format SHALL be: idle low, start bit 1, DATA_W data bits LSB first, stop bit 0.
REQ-014 Each laser_in bit SHALL pass through a 2-flop synchronizer; all lane logic uses the synchronized value.
REQ-015 Each lane SHALL run an FSM with states IDLE, START, DATA, STOP and a phase counter 0..OVERSAMPLE-1.
REQ-016 IDLE->START on a synchronized 0->1 edge; phase counter loads 0 on that cycle.
REQ-017 In every bit period, the lane SHALL sample at phase M-1, M and M+1 (M = OVERSAMPLE/2) and decide the bit at phase OVERSAMPLE-1 by majority (>=2 of 3 ones = 1).
REQ-018 START decided 0 (false start) SHALL return the lane to IDLE and pulse frame_err[i]; decided 1 -> DATA.
REQ-019 DATA SHALL shift in exactly DATA_W decided bits, then -> STOP.
REQ-020 STOP decided 0 SHALL commit the byte; decided 1 SHALL pulse frame_err[i] and discard the byte; both -> IDLE.
REQ-021 Commit SHALL write the lane buffer and set lane_full[i] one cycle after the stop decision.
REQ-022 If lane_full[i] is already set at commit, the new byte SHALL be dropped, the buffer kept, and overrun[i] set.
REQ-023 out_valid SHALL be the AND of all lane_full bits; out_data is the lane buffers concatenated.
REQ-024 A handshake (out_valid & out_ready) SHALL clear all lane_full bits next cycle. A commit on the same cycle as the handshake writes the buffer and leaves lane_full[i] = 1; it is not an overrun.
REQ-025 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 overrun_clr SHALL clear overrun; a simultaneous set takes priority.
REQ-027 Lanes SHALL operate independently; inter-lane skew of any amount is tolerated by buffering.

Reset
REQ-028 On reset all lanes -> IDLE; phase counters, vote counters, buffers and lane_full = 0.
REQ-029 out_valid, frame_err and overrun SHALL be 0 during and after reset; out_data = 0.
REQ-030 Synchronizer flops SHALL reset to 0; reset mid-frame SHALL abandon the frame with no frame_err.

Structure
REQ-031 Package laser_pkg holds the lane state enum (IDLE, START, DATA, STOP) and the line-polarity constants IDLE_LVL=0, START_LVL=1, STOP_LVL=0.
REQ-032 Sub-module laser_rx_lane (synchronizer, FSM, voter, shift register) is instantiated CHANNELS times via generate; the top holds the buffers and the handshake.

Verification (CHANNELS=2, DATA_W=8, OVERSAMPLE=8)
REQ-033 Both lanes send 0xA5 / 0x3C aligned, out_ready=1 -> out_valid pulses once, out_data=16'h3CA5, no frame_err.
REQ-034 Lane1 lags lane0 by 37 cycles, bytes 0x01 / 0xFF -> out_valid only after the lane1 commit, out_data=16'hFF01.
REQ-035 Single-cycle glitch on phase M of data bit 3 of 0x00 -> byte still 0x00 (majority vote).
REQ-036 Stop bit held 1 on lane0 -> frame_err[0] pulses one cycle, lane_full[0] stays 0, out_valid stays 0.
REQ-037 out_ready=0, lane0 receives two frames 0x11 then 0x22 -> buffer keeps 0x11, overrun[0]=1 until overrun_clr.
REQ-038 reset asserted at phase 3 of data bit 4 -> all outputs 0; the next clean frame 0x5A/0x5A yields out_data=16'h5A5A.
